// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
// occ_t holds the 0..2 count of words sitting in the output buffer.
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // Buffered words after this cycle: what is held, plus a landing word, minus a pop.
  function automatic occ_t occ_next_f(occ_t occ, logic inflight, logic pop);
    return occ_t'(occ + occ_t'(inflight) - occ_t'(pop));
  endfunction

endpackage

// File: rtl/fifo_rd_buf2.sv
// Two-entry output buffer: entry 0 is the head, entry 1 the tail.
// The head is written directly or refilled from the tail when the head is consumed.
module fifo_rd_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_head,
  input  logic                  wr_tail,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] entry [BUF_DEPTH];

  // A direct head write takes priority; it only happens when the tail holds nothing useful.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry[0] <= '0;
      entry[1] <= '0;
    end else begin
      if (wr_head) begin
        entry[0] <= wr_data;
      end else if (shift) begin
        entry[0] <= entry[1];
      end
      if (wr_tail) begin
        entry[1] <= wr_data;
      end
    end
  end

  assign head_data = entry[0];

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns the FIFO's registered-read port into a first-word-fall-through valid/ready stream,
// prefetching into a 2-entry buffer so a word per cycle flows under continuous m_ready.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [1:0]            level,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  occ_t occ;
  occ_t occ_nxt;
  logic inflight;
  logic pop;
  logic land_head;
  logic wr_head;
  logic wr_tail;
  logic shift;

  assign pop     = m_valid & m_ready;
  assign occ_nxt = occ_next_f(occ, inflight, pop);

  // m_ready reaches fifo_r_en combinationally so a pop frees a slot in the same cycle.
  assign fifo_r_en = !rrst & !flush & !fifo_empty & (occ_nxt <= occ_t'(1));

  // A landing word goes to the head when the head is empty or being vacated this cycle.
  assign land_head = (occ == occ_t'(0)) | ((occ == occ_t'(1)) & pop);
  assign wr_head   = inflight & !flush & land_head;
  assign wr_tail   = inflight & !flush & !land_head;
  assign shift     = pop & !flush & (occ == occ_t'(2));

  // Flush drops buffered and landing words but keeps the delivered-word count.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ      <= '0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else if (flush) begin
      occ      <= '0;
      inflight <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      inflight <= fifo_r_en;
      if (pop) begin
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
    end
  end

  assign m_valid = (occ != occ_t'(0));
  assign level   = occ;

  fifo_rd_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (rclk),
    .rst      (rrst),
    .wr_head  (wr_head),
    .wr_tail  (wr_tail),
    .shift    (shift),
    .wr_data  (fifo_data),
    .head_data(m_data)
  );

endmodule
